// File: rtl/quad_input_conditioner.sv
// Quadrature input conditioner: 2-FF synchronisers and per-channel debounce for
// encoder pins A/B, with change pulse, sticky simultaneous-edge error and glitch counter.
module quad_input_conditioner #(
    parameter int DEB_CYC = 8,
    localparam int CNT_W = $clog2(DEB_CYC)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_raw,
    input  logic       b_raw,
    input  logic       err_clr,
    output logic       a,
    output logic       b,
    output logic       chg,
    output logic       err,
    output logic [7:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

    logic             a_s1_p0, a_s2_p1;
    logic             b_s1_p0, b_s2_p1;
    logic [CNT_W-1:0] a_cnt, b_cnt;
    logic [CNT_W+1:0] a_step, b_step;
    logic             a_upd, a_glt, b_upd, b_glt;

    // Returns {update, glitch, next_count} for one channel.
    function automatic logic [CNT_W+1:0] deb_step(input logic s, input logic q,
                                                 input logic [CNT_W-1:0] cnt);
        logic             upd;
        logic             glt;
        logic [CNT_W-1:0] nxt;
        upd = 1'b0;
        glt = 1'b0;
        nxt = cnt;
        if (s != q) begin
            if (cnt == CNT_MAX) begin
                upd = 1'b1;
                nxt = '0;
            end else begin
                nxt = cnt + 1'b1;
            end
        end else if (cnt != '0) begin
            glt = 1'b1;
            nxt = '0;
        end
        return {upd, glt, nxt};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] x, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, x} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    always_comb begin
        a_step = deb_step(a_s2_p1, a, a_cnt);
        b_step = deb_step(b_s2_p1, b, b_cnt);
        a_upd  = a_step[CNT_W+1];
        a_glt  = a_step[CNT_W];
        b_upd  = b_step[CNT_W+1];
        b_glt  = b_step[CNT_W];
    end

    // Stage p0/p1: synchroniser; debounce and flags run off the p1 sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_s1_p0    <= 1'b1;
            a_s2_p1    <= 1'b1;
            b_s1_p0    <= 1'b1;
            b_s2_p1    <= 1'b1;
            a_cnt      <= '0;
            b_cnt      <= '0;
            a          <= 1'b1;
            b          <= 1'b1;
            chg        <= 1'b0;
            err        <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            a_s1_p0 <= a_raw;
            a_s2_p1 <= a_s1_p0;
            b_s1_p0 <= b_raw;
            b_s2_p1 <= b_s1_p0;
            a_cnt   <= a_step[CNT_W-1:0];
            b_cnt   <= b_step[CNT_W-1:0];
            if (a_upd) a <= a_s2_p1;
            if (b_upd) b <= b_s2_p1;
            chg <= a_upd | b_upd;
            // A simultaneous update outranks a pending clear.
            if (a_upd && b_upd) err <= 1'b1;
            else if (err_clr)   err <= 1'b0;
            glitch_cnt <= sat_add(glitch_cnt, {1'b0, a_glt} + {1'b0, b_glt});
        end
    end

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Scoreboard bench for quad_input_conditioner: a behavioural model predicts every
// output per edge, plus directed checks on latency, glitch, error and saturation cases.
module tb_quad_input_conditioner;

    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_raw = 1'b1;
    logic       b_raw = 1'b1;
    logic       err_clr = 1'b0;
    logic       a, b, chg, err;
    logic [7:0] glitch_cnt;

    always #5 clk = ~clk;

    quad_input_conditioner #(.DEB_CYC(DEB)) dut (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .err_clr(err_clr),
        .a(a), .b(b), .chg(chg), .err(err), .glitch_cnt(glitch_cnt)
    );

    typedef struct {
        logic       a;
        logic       b;
        logic       chg;
        logic       err;
        logic [7:0] gc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    // Behavioural model state: pin sample history and run length of differing samples.
    logic m_s1[2] = '{1'b1, 1'b1};
    logic m_s2[2] = '{1'b1, 1'b1};
    logic m_q[2]  = '{1'b1, 1'b1};
    int   m_run[2] = '{0, 0};
    logic m_chg = 1'b0;
    logic m_err = 1'b0;
    int   m_gc = 0;

    int   qcyc, nchg, ta_fall, tb_fall, ta_rise, tb_rise;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic model_edge();
        logic raw[2];
        bit   upd[2];
        int   gl;
        exp_t e;
        raw[0] = a_raw;
        raw[1] = b_raw;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_q[i] = 1'b1; m_run[i] = 0;
            end
            m_chg = 1'b0;
            m_err = 1'b0;
            m_gc  = 0;
        end else begin
            gl = 0;
            for (int i = 0; i < 2; i++) begin
                upd[i] = 1'b0;
                if (m_s2[i] != m_q[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_q[i]   = m_s2[i];
                        m_run[i] = 0;
                        upd[i]   = 1'b1;
                    end
                end else if (m_run[i] != 0) begin
                    m_run[i] = 0;
                    gl++;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
            m_chg = upd[0] | upd[1];
            if (upd[0] && upd[1]) m_err = 1'b1;
            else if (err_clr)     m_err = 1'b0;
            m_gc = (m_gc + gl > 255) ? 255 : m_gc + gl;
        end
        e.a = m_q[0]; e.b = m_q[1]; e.chg = m_chg; e.err = m_err; e.gc = 8'(m_gc);
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            check("sb_a", a, e.a);
            check("sb_b", b, e.b);
            check("sb_chg", chg, e.chg);
            check("sb_err", err, e.err);
            check("sb_gc", glitch_cnt, e.gc);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic watch(input int n);
        logic pa, pb;
        repeat (n) begin
            pa = a;
            pb = b;
            tick();
            qcyc++;
            if (chg === 1'b1) nchg++;
            if (pa === 1'b1 && a === 1'b0) ta_fall = qcyc;
            if (pa === 1'b0 && a === 1'b1) ta_rise = qcyc;
            if (pb === 1'b1 && b === 1'b0) tb_fall = qcyc;
            if (pb === 1'b0 && b === 1'b1) tb_rise = qcyc;
        end
    endtask

    task automatic watch_reset();
        qcyc = 0; nchg = 0; ta_fall = -1; tb_fall = -1; ta_rise = -1; tb_rise = -1;
    endtask

    task automatic glitch(input bit on_a, input bit on_b);
        if (on_a) a_raw = 1'b0;
        if (on_b) b_raw = 1'b0;
        ticks(2);
        a_raw = 1'b1;
        b_raw = 1'b1;
        ticks(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int gc0;
        int na;

        // Reset held with pins low, then release.
        rst = 1'b0; a_raw = 1'b0; b_raw = 1'b0;
        ticks(5);
        check("rst_a", a, 1);
        check("rst_gc", glitch_cnt, 0);
        rst = 1'b1;
        watch_reset();
        watch(1);
        check("rel_a", a, 1);
        check("rel_b", b, 1);
        check("rel_chg", chg, 0);
        check("rel_err", err, 0);
        check("rel_gc", glitch_cnt, 0);
        while (a !== 1'b0 && qcyc < 30) watch(1);
        check("rel_lat", qcyc, 10);
        check("rel_b_same", tb_fall, 10);
        check("rel_chg_pulse", chg, 1);
        check("rel_err_set", err, 1);
        watch(1);
        check("rel_chg_once", chg, 0);

        // Back to idle, clear error.
        a_raw = 1'b1; ticks(15);
        b_raw = 1'b1; ticks(15);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("idle_err", err, 0);

        // Clean quadrature increment, 200 ns between pin steps.
        gc0 = glitch_cnt;
        watch_reset();
        a_raw = 1'b0; watch(20);
        b_raw = 1'b0; watch(20);
        a_raw = 1'b1; watch(20);
        b_raw = 1'b1; watch(25);
        check("quad_a_fall", ta_fall, 10);
        check("quad_b_fall", tb_fall, 30);
        check("quad_a_rise", ta_rise, 50);
        check("quad_b_rise", tb_rise, 70);
        check("quad_nchg", nchg, 4);
        check("quad_err", err, 0);
        check("quad_gc", glitch_cnt, gc0);

        // Short pulse rejected; exactly DEB-long pulse accepted.
        watch_reset();
        a_raw = 1'b0; watch(5);
        a_raw = 1'b1; watch(12);
        check("gl_a", a, 1);
        check("gl_nchg", nchg, 0);
        check("gl_gc", glitch_cnt, gc0 + 1);
        watch_reset();
        a_raw = 1'b0; watch(8);
        a_raw = 1'b1; watch(20);
        check("pulse8_fell", ta_fall, 10);
        check("pulse8_nchg", nchg, 2);
        check("pulse8_gc", glitch_cnt, gc0 + 1);

        // Simultaneous update and err_clr priority.
        a_raw = 1'b0; b_raw = 1'b0; ticks(10);
        check("sim_a", a, 0);
        check("sim_b", b, 0);
        check("sim_chg", chg, 1);
        check("sim_err", err, 1);
        tick();
        check("sim_chg_once", chg, 0);
        a_raw = 1'b1; b_raw = 1'b1; ticks(9);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("setwin_a", a, 1);
        check("setwin_err", err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr_err", err, 0);
        ticks(3);

        // Glitch counter saturation.
        na = 0;
        while (m_gc < 240) begin
            glitch(1'b1, 1'b0); na++;
            glitch(1'b1, 1'b1);
        end
        while (m_gc < 254) begin
            glitch(1'b1, 1'b0); na++;
        end
        check("sat_254", glitch_cnt, 254);
        glitch(1'b1, 1'b1);
        check("sat_dual", glitch_cnt, 255);
        while (na < 300) begin
            glitch(1'b1, 1'b0); na++;
        end
        check("sat_hold", glitch_cnt, 255);
        check("sat_a", a, 1);

        // Reset mid-count with err set.
        a_raw = 1'b0; b_raw = 1'b0; ticks(12);
        a_raw = 1'b1; b_raw = 1'b1; ticks(12);
        check("mid_err", err, 1);
        a_raw = 1'b0;
        n = 0;
        while (m_run[0] != 6 && n < 20) begin tick(); n++; end
        check("mid_cnt6", m_run[0], 6);
        rst = 1'b0;
        tick();
        check("mid_rst_a", a, 1);
        check("mid_rst_b", b, 1);
        check("mid_rst_chg", chg, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_gc", glitch_cnt, 0);
        rst = 1'b1;
        watch_reset();
        while (a !== 1'b0 && qcyc < 30) watch(1);
        check("mid_lat", qcyc, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_input_conditioner.md
Name: quad_input_conditioner

Overview:
Input conditioning stage sitting directly upstream of the rotary decoder. It takes the raw, asynchronous, bouncing quadrature pins A/B from the encoder. It synchronises and debounces each channel, then presents clean, idle-high levels to the decoder's a/b inputs. It also flags illegal simultaneous A/B transitions and counts rejected glitches for diagnostics.

Parameters:
DEB_CYC, 8, consecutive sync'd cycles a channel must differ from its output before the output updates (>=2)
CNT_W, $clog2(DEB_CYC), width of per-channel debounce counter (derived, not overridden)

Ports:
clk  input  1  system clock (100 MHz nominal)
rst  input  1  synchronous reset, active-low: block resets on a rising clk edge while rst==0
a_raw  input  1  raw encoder pin A, asynchronous, idle high
b_raw  input  1  raw encoder pin B, asynchronous, idle high
a  output  1  debounced A level, feeds rotary decoder a
b  output  1  debounced B level, feeds rotary decoder b
chg  output  1  one-cycle pulse when a or b (or both) updates
err  output  1  sticky: a and b updated on the same cycle
err_clr  input  1  clears err
glitch_cnt  output  8  saturating count of rejected glitches

Behaviour:
- Reset (rst==0 at clk edge): sync FFs=1, a=1, b=1, both debounce counters=0, chg=0, err=0, glitch_cnt=0. Reset overrides everything, including mid-count and mid-glitch.
- Sync: each channel uses a 2-FF synchroniser, s1<=raw, s2<=s1. No logic sits between s1 and s2.
- Debounce, per channel with output q and counter cnt:
  - s2!=q and cnt<DEB_CYC-1: cnt<=cnt+1.
  - s2!=q and cnt==DEB_CYC-1: q<=s2, cnt<=0.
  - s2==q and cnt!=0: glitch rejected, cnt<=0, glitch event.
  - s2==q and cnt==0: hold.
- Latency: a clean pin step first sampled at edge e1 appears on q after edge e1+1+DEB_CYC. With default DEB_CYC=8 the output changes 10 edges after first sampling.
- Pulses shorter than DEB_CYC sync'd cycles never reach q.
- chg: registered; high for exactly the one cycle in which a or b holds its new value for the first time.
- err:
  - Set when a and b both update on the same edge.
  - err_clr==1 clears it on the next edge.
  - Set and clear on the same edge: set wins.
  - Both outputs still update normally when err is set.
- glitch_cnt:
  - +1 per channel glitch event; if both channels glitch on the same edge, +2.
  - Saturates at 255, never wraps.
  - Cleared only by reset.
- No handshake. The outputs are levels sampled by the decoder every clk.

Test Plan:
- Reset: hold rst=0 with a_raw=b_raw=0 for 5 cycles, release -> a=b=1, chg=0, err=0, glitch_cnt=0 immediately after release, then a falls to 0 exactly 10 edges later, b falls on the same edge, chg pulses once, err=1.
- Clean quadrature: increment sequence (a_raw low, 200 ns later b_raw low, then a_raw high, then b_raw high) -> a/b follow each step after 10 cycles with the same ordering and spacing, 4 chg pulses, err=0, glitch_cnt=0.
- Glitch reject: a_raw low for 5 cycles, then high -> a stays 1, no chg, glitch_cnt=1. Repeat with a_raw low for exactly 8 sync'd cycles -> a falls, chg pulses, glitch_cnt unchanged.
- Simultaneous and err_clr: drive a_raw and b_raw low on the same edge -> a and b fall together, chg=1 one cycle, err=1. Assert err_clr on the same edge as a new simultaneous update -> err stays 1. Assert err_clr alone -> err=0 next cycle.
- Saturation: 300 rejected glitches on A, interleaved with dual-channel glitches -> glitch_cnt reaches 255 and holds. A dual glitch at 254 -> 255, not 0.
- Reset mid-operation: assert rst=0 while cnt=6 on channel A and err=1 -> next edge all outputs at reset values. After release, the stale partial count is discarded and a full 10-cycle latency applies.
